// File: rtl/cpu_id_scoreboard.sv
// Decode-stage operand hazard unit: per-register pending-latency scoreboard,
// N-port priority forwarding mux, stall request and issue strobe generation.
module cpu_id_scoreboard #(
   parameter int NUM_FWD = 3,
   parameter int MAX_LAT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          ex_ready,
   input  logic                          id_valid,
   input  logic [4:0]                    rs_addr,
   input  logic [4:0]                    rt_addr,
   input  logic                          uses_rs,
   input  logic                          uses_rt,
   input  logic [31:0]                   rf_rdata1,
   input  logic [31:0]                   rf_rdata2,
   input  logic                          issue_we,
   input  logic [4:0]                    issue_waddr,
   input  logic [$clog2(MAX_LAT+1)-1:0]  issue_lat,
   input  logic [NUM_FWD-1:0]            fwd_we,
   input  logic [NUM_FWD*5-1:0]          fwd_waddr,
   input  logic [NUM_FWD*32-1:0]         fwd_wdata,
   output logic [31:0]                   opnd1,
   output logic [31:0]                   opnd2,
   output logic                          stall_req,
   output logic                          issue_fire,
   output logic [31:0]                   busy_mask,
   output logic [31:0]                   stall_cycles
);

   localparam int LAT_W = $clog2(MAX_LAT+1);
   localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);

   logic [LAT_W-1:0] cnt      [32];
   logic [LAT_W-1:0] cnt_next [32];
   logic [LAT_W-1:0] lat_clamped;
   logic [31:0]      busy_next;
   logic             hazard_rs;
   logic             hazard_rt;
   logic             rs_hit;
   logic             rt_hit;
   int unsigned      lat_wide;

   assign hazard_rs  = uses_rs && (rs_addr != 5'd0) && (cnt[rs_addr] != '0);
   assign hazard_rt  = uses_rt && (rt_addr != 5'd0) && (cnt[rt_addr] != '0);
   assign stall_req  = id_valid && (hazard_rs || hazard_rt);
   assign issue_fire = id_valid && !stall_req && ex_ready && !flush;

   always_comb begin
      lat_wide    = 32'(issue_lat);
      lat_clamped = issue_lat;
      if (lat_wide > MAX_LAT)
         lat_clamped = LAT_MAX_V;
   end

   // Next-state counters: flush kills everything, otherwise age on advance,
   // then the newly issued producer overwrites its destination (newest wins).
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         cnt_next[r] = cnt[r];
         if (flush)
            cnt_next[r] = '0;
         else if (ex_ready && cnt[r] != '0)
            cnt_next[r] = cnt[r] - 1'b1;
      end
      if (!flush && issue_fire && issue_we && issue_waddr != 5'd0)
         cnt_next[issue_waddr] = lat_clamped;
      cnt_next[0] = '0;
      for (int r = 0; r < 32; r++)
         busy_next[r] = (cnt_next[r] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++)
            cnt[r] <= '0;
         busy_mask    <= '0;
         stall_cycles <= '0;
      end else begin
         for (int r = 0; r < 32; r++)
            cnt[r] <= cnt_next[r];
         busy_mask <= busy_next;
         if (stall_req && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

   // Scan from the oldest port down so the youngest matching port is the last writer.
   always_comb begin
      opnd1  = rf_rdata1;
      opnd2  = rf_rdata2;
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = NUM_FWD-1; i >= 0; i--) begin
         if (fwd_we[i] && fwd_waddr[5*i +: 5] == rs_addr) begin
            opnd1  = fwd_wdata[32*i +: 32];
            rs_hit = 1'b1;
         end
         if (fwd_we[i] && fwd_waddr[5*i +: 5] == rt_addr) begin
            opnd2  = fwd_wdata[32*i +: 32];
            rt_hit = 1'b1;
         end
      end
      if (rs_addr == 5'd0)
         opnd1 = 32'd0;
      if (rt_addr == 5'd0)
         opnd2 = 32'd0;
   end

endmodule

// File: tb/tb_cpu_id_scoreboard.sv
// Directed bench for cpu_id_scoreboard: load-use, ALU chain, long latency,
// ex_ready hold, flush, r0 handling, WAW and forwarding priority.
module tb_cpu_id_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ex_ready;
   logic        id_valid;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        uses_rs;
   logic        uses_rt;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        issue_we;
   logic [4:0]  issue_waddr;
   logic [1:0]  issue_lat;
   logic [2:0]  fwd_we;
   logic [14:0] fwd_waddr;
   logic [95:0] fwd_wdata;
   logic [31:0] opnd1;
   logic [31:0] opnd2;
   logic        stall_req;
   logic        issue_fire;
   logic [31:0] busy_mask;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_id_scoreboard #(.NUM_FWD(3), .MAX_LAT(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .uses_rs(uses_rs), .uses_rt(uses_rt),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .issue_we(issue_we),
      .issue_waddr(issue_waddr), .issue_lat(issue_lat), .fwd_we(fwd_we),
      .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .opnd1(opnd1), .opnd2(opnd2),
      .stall_req(stall_req), .issue_fire(issue_fire), .busy_mask(busy_mask),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decode-side inputs; forwarding ports are cleared and set separately.
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt, input logic we,
                                input logic [4:0] wa, input logic [1:0] lat);
      id_valid    = v;
      rs_addr     = rs;
      uses_rs     = urs;
      rt_addr     = rt;
      uses_rt     = urt;
      issue_we    = we;
      issue_waddr = wa;
      issue_lat   = lat;
      fwd_we      = 3'b000;
      fwd_waddr   = '0;
      fwd_wdata   = '0;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      #1;
      checkOutput("reset_busy", busy_mask, 32'h0);
      checkOutput("reset_stallcnt", stall_cycles, 32'h0);
      checkOutput("reset_stall", {31'd0, stall_req}, 32'd0);
      checkOutput("reset_fire", {31'd0, issue_fire}, 32'd0);

      $display("[TB] load-use");
      applyStimulus(1, 0, 0, 0, 0, 1, 5, 1);
      checkOutput("lw_fire", {31'd0, issue_fire}, 32'd1);
      tick();
      applyStimulus(1, 5, 1, 5, 1, 1, 6, 0);
      checkOutput("lu_stall", {31'd0, stall_req}, 32'd1);
      checkOutput("lu_nofire", {31'd0, issue_fire}, 32'd0);
      checkOutput("lu_busy", busy_mask, 32'h0000_0020);
      tick();
      applyStimulus(1, 5, 1, 5, 1, 1, 6, 0);
      fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd5, 5'd0}; fwd_wdata = {32'd0, 32'hCAFE_0005, 32'd0};
      #1;
      checkOutput("lu_go_stall", {31'd0, stall_req}, 32'd0);
      checkOutput("lu_opnd1", opnd1, 32'hCAFE_0005);
      checkOutput("lu_opnd2", opnd2, 32'hCAFE_0005);
      checkOutput("lu_busy0", busy_mask, 32'h0);
      checkOutput("lu_stallcnt", stall_cycles, 32'd1);
      tick();

      $display("[TB] ALU chain");
      applyStimulus(1, 0, 0, 0, 0, 1, 3, 0);
      checkOutput("alu_fire", {31'd0, issue_fire}, 32'd1);
      tick();
      applyStimulus(1, 3, 1, 10, 1, 0, 0, 0);
      rf_rdata2 = 32'h5555_AAAA;
      fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd3}; fwd_wdata = {32'd0, 32'd0, 32'h0000_1234};
      #1;
      checkOutput("alu_stall", {31'd0, stall_req}, 32'd0);
      checkOutput("alu_opnd1", opnd1, 32'h0000_1234);
      checkOutput("alu_opnd2_rf", opnd2, 32'h5555_AAAA);
      tick();

      $display("[TB] long latency");
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 3);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("ll_stall%0d", k), {31'd0, stall_req}, 32'd1);
         if (k == 0) checkOutput("ll_busy", busy_mask, 32'h0000_0080);
         tick();
      end
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
      checkOutput("ll_go", {31'd0, stall_req}, 32'd0);
      checkOutput("ll_fire", {31'd0, issue_fire}, 32'd1);
      checkOutput("ll_stallcnt", stall_cycles, 32'd4);
      tick();

      $display("[TB] ex_ready hold");
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 2);
      tick();
      ex_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("hold_stall%0d", k), {31'd0, stall_req}, 32'd1);
         checkOutput($sformatf("hold_busy%0d", k), busy_mask, 32'h0000_0080);
         tick();
      end
      ex_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("adv_stall%0d", k), {31'd0, stall_req}, 32'd1);
         tick();
      end
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
      checkOutput("hold_go", {31'd0, stall_req}, 32'd0);
      checkOutput("hold_stallcnt", stall_cycles, 32'd8);
      tick();

      $display("[TB] flush");
      flush = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 1, 9, 2);
      checkOutput("flush_nofire", {31'd0, issue_fire}, 32'd0);
      tick();
      flush = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 1, 9, 2);
      checkOutput("flush_busy_a", busy_mask, 32'h0);
      tick();
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0);
      flush = 1'b1;
      #1;
      checkOutput("flush_stall", {31'd0, stall_req}, 32'd1);
      checkOutput("flush_busy_b", busy_mask, 32'h0000_0200);
      tick();
      flush = 1'b0;
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0);
      checkOutput("postflush_busy", busy_mask, 32'h0);
      checkOutput("postflush_stall", {31'd0, stall_req}, 32'd0);
      checkOutput("postflush_fire", {31'd0, issue_fire}, 32'd1);
      checkOutput("postflush_stallcnt", stall_cycles, 32'd9);
      tick();

      $display("[TB] r0 handling");
      applyStimulus(1, 0, 1, 0, 1, 1, 0, 3);
      fwd_we = 3'b001; fwd_waddr = 15'd0; fwd_wdata = {32'd0, 32'd0, 32'h0000_FFFF};
      #1;
      checkOutput("r0_opnd1", opnd1, 32'h0);
      checkOutput("r0_opnd2", opnd2, 32'h0);
      checkOutput("r0_stall", {31'd0, stall_req}, 32'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("r0_busy", busy_mask, 32'h0);

      $display("[TB] WAW");
      applyStimulus(1, 0, 0, 0, 0, 1, 4, 3);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 1, 4, 0);
      checkOutput("waw_busy1", busy_mask, 32'h0000_0010);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("waw_busy0", busy_mask, 32'h0);

      $display("[TB] forwarding priority");
      applyStimulus(1, 8, 1, 8, 1, 0, 0, 0);
      fwd_we = 3'b101; fwd_waddr = {5'd8, 5'd8, 5'd8};
      fwd_wdata = {32'h2222_0000, 32'h3333_0000, 32'h1111_0000};
      #1;
      checkOutput("prio_p0_opnd1", opnd1, 32'h1111_0000);
      checkOutput("prio_p0_opnd2", opnd2, 32'h1111_0000);
      fwd_we = 3'b110;
      #1;
      checkOutput("prio_p1_opnd1", opnd1, 32'h3333_0000);
      fwd_we = 3'b100;
      #1;
      checkOutput("prio_p2_opnd2", opnd2, 32'h2222_0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
